// File: rtl/freq_setter_pkg.sv
// Shared types, step lookup and default timing for the freq_setter front panel.
package freq_setter_pkg;

   localparam int unsigned DEFAULT_DEBOUNCE_MS     = 20;
   localparam int unsigned DEFAULT_REPEAT_DELAY_MS = 500;
   localparam int unsigned DEFAULT_REPEAT_RATE_MS  = 100;
   localparam int unsigned DEFAULT_FREQ_RESET      = 1000;
   localparam int unsigned DEFAULT_FREQ_MAX        = 9999;

   // One bit wider than freq so an up step can never wrap before it is saturated.
   typedef logic [16:0] freq_calc_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } hold_state_e;

   function automatic freq_calc_t stepSize(input logic [1:0] sel);
      case (sel)
         2'd0:    return freq_calc_t'(1);
         2'd1:    return freq_calc_t'(10);
         2'd2:    return freq_calc_t'(100);
         default: return freq_calc_t'(1000);
      endcase
   endfunction

endpackage

// File: rtl/freq_setter_btn_debounce.sv
// Two-flop synchronizer followed by a debouncer: the accepted level only flips
// after DEBOUNCE_MS consecutive synchronized samples disagree with it.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic clk_scan,
   input  logic rst,
   input  logic btn_raw_i,
   output logic btn_level_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);
   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t CntLast = cnt_t'(DEBOUNCE_MS - 1);

   logic [1:0] sync_q;
   logic       level_q, level_d;
   cnt_t       cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk_scan or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_level_o = level_q;

endmodule

// File: rtl/freq_setter.sv
// Frequency setpoint from debounced up/down/step buttons with saturating steps.
// Hold-to-repeat is built only when FREQ_SETTER_AUTOREPEAT_EN is defined.
module freq_setter
   import freq_setter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS     = DEFAULT_DEBOUNCE_MS,
   parameter int unsigned REPEAT_DELAY_MS = DEFAULT_REPEAT_DELAY_MS,
   parameter int unsigned REPEAT_RATE_MS  = DEFAULT_REPEAT_RATE_MS,
   parameter int unsigned FREQ_RESET      = DEFAULT_FREQ_RESET,
   parameter int unsigned FREQ_MAX        = DEFAULT_FREQ_MAX
) (
   input  logic        clk_scan,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_step,
   output logic [15:0] freq,
   output logic [1:0]  step_sel,
   output logic        freq_changed
);

   localparam freq_calc_t  FreqMaxW    = freq_calc_t'(FREQ_MAX);
   localparam logic [15:0] FreqMax16   = 16'(FREQ_MAX);
   localparam logic [15:0] FreqReset16 = 16'(FREQ_RESET);

   if (DEBOUNCE_MS == 0 || REPEAT_DELAY_MS == 0 || REPEAT_RATE_MS == 0 ||
       FREQ_MAX > 65535 || FREQ_RESET > FREQ_MAX) begin : gBadParams
      $error("freq_setter: unsupported parameter set");
   end

   logic        upLvl, dnLvl, stepLvl;
   logic        upPrev_q, dnPrev_q, stepPrev_q;
   logic        upRise, dnRise, stepRise, bothHeld, activeLvl;
   hold_state_e state_q, state_d;
   logic        dirUp_q, dirUp_d;
   logic        lockout_q, lockout_d;
   logic        applyStep;
   logic [15:0] freq_q, freq_d;
   logic [1:0]  stepSel_q, stepSel_d;
   logic        freqChanged_q, freqChanged_d;
   freq_calc_t  stepVal;

`ifdef FREQ_SETTER_AUTOREPEAT_EN
   localparam int unsigned HoldSpan = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int unsigned HoldCntW = $clog2(HoldSpan + 1);
   typedef logic [HoldCntW-1:0] hold_cnt_t;
   localparam hold_cnt_t DelayLast = hold_cnt_t'(REPEAT_DELAY_MS - 1);
   localparam hold_cnt_t RateLast  = hold_cnt_t'(REPEAT_RATE_MS - 1);
   hold_cnt_t holdCnt_q, holdCnt_d;
`endif

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) uBtnUp (
      .clk_scan(clk_scan), .rst(rst), .btn_raw_i(btn_up), .btn_level_o(upLvl));
   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) uBtnDown (
      .clk_scan(clk_scan), .rst(rst), .btn_raw_i(btn_down), .btn_level_o(dnLvl));
   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) uBtnStep (
      .clk_scan(clk_scan), .rst(rst), .btn_raw_i(btn_step), .btn_level_o(stepLvl));

   assign upRise    = upLvl & ~upPrev_q;
   assign dnRise    = dnLvl & ~dnPrev_q;
   assign stepRise  = stepLvl & ~stepPrev_q;
   assign bothHeld  = upLvl & dnLvl;
   assign activeLvl = dirUp_q ? upLvl : dnLvl;

   // Both buttons down cancels the press and locks out until both are released.
   always_comb begin
      state_d   = state_q;
      dirUp_d   = dirUp_q;
      lockout_d = lockout_q;
      applyStep = 1'b0;
`ifdef FREQ_SETTER_AUTOREPEAT_EN
      holdCnt_d = holdCnt_q;
`endif
      if (bothHeld) begin
         state_d   = IDLE;
         lockout_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (lockout_q) begin
                  if (!upLvl && !dnLvl) lockout_d = 1'b0;
               end else if (upRise || dnRise) begin
                  applyStep = 1'b1;
                  dirUp_d   = upRise;
                  state_d   = HOLD_WAIT;
`ifdef FREQ_SETTER_AUTOREPEAT_EN
                  holdCnt_d = '0;
`endif
               end
            end
            HOLD_WAIT: begin
               if (!activeLvl) begin
                  state_d = IDLE;
`ifdef FREQ_SETTER_AUTOREPEAT_EN
               end else if (holdCnt_q == DelayLast) begin
                  applyStep = 1'b1;
                  state_d   = REPEAT;
                  holdCnt_d = '0;
               end else begin
                  holdCnt_d = holdCnt_q + hold_cnt_t'(1);
`endif
               end
            end
            REPEAT: begin
`ifdef FREQ_SETTER_AUTOREPEAT_EN
               if (!activeLvl) begin
                  state_d = IDLE;
               end else if (holdCnt_q == RateLast) begin
                  applyStep = 1'b1;
                  holdCnt_d = '0;
               end else begin
                  holdCnt_d = holdCnt_q + hold_cnt_t'(1);
               end
`else
               state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Step size is sampled at apply time, so a step_sel change affects the next step.
   always_comb begin
      freq_d        = freq_q;
      freqChanged_d = 1'b0;
      stepSel_d     = stepSel_q;
      stepVal       = stepSize(stepSel_q);
      if (stepRise) stepSel_d = stepSel_q + 2'd1;
      if (applyStep) begin
         if (dirUp_d) begin
            if (({1'b0, freq_q} + stepVal) > FreqMaxW) freq_d = FreqMax16;
            else                                       freq_d = freq_q + stepVal[15:0];
         end else begin
            if ({1'b0, freq_q} < stepVal) freq_d = 16'd0;
            else                          freq_d = freq_q - stepVal[15:0];
         end
         freqChanged_d = (freq_d != freq_q);
      end
   end

   always_ff @(posedge clk_scan or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         dirUp_q       <= 1'b0;
         lockout_q     <= 1'b0;
         upPrev_q      <= 1'b0;
         dnPrev_q      <= 1'b0;
         stepPrev_q    <= 1'b0;
         freq_q        <= FreqReset16;
         stepSel_q     <= 2'd0;
         freqChanged_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dirUp_q       <= dirUp_d;
         lockout_q     <= lockout_d;
         upPrev_q      <= upLvl;
         dnPrev_q      <= dnLvl;
         stepPrev_q    <= stepLvl;
         freq_q        <= freq_d;
         stepSel_q     <= stepSel_d;
         freqChanged_q <= freqChanged_d;
      end
   end

`ifdef FREQ_SETTER_AUTOREPEAT_EN
   always_ff @(posedge clk_scan or posedge rst) begin
      if (rst) holdCnt_q <= '0;
      else     holdCnt_q <= holdCnt_d;
   end
`endif

   assign freq         = freq_q;
   assign step_sel     = stepSel_q;
   assign freq_changed = freqChanged_q;

endmodule

// File: tb/tb_freq_setter.sv
// Self-checking bench for freq_setter: directed scenarios plus random presses,
// checked against a step-rule model of the front panel.
module tb_freq_setter;

   localparam int Deb           = 20;
   localparam int Latency       = 2 + Deb + 1;
   localparam int RepeatDelay   = 500;
   localparam int RepeatRate    = 100;
   localparam int FreqMax       = 9999;
   localparam int FreqReset     = 1000;
`ifdef FREQ_SETTER_AUTOREPEAT_EN
   localparam bit AutoRepeat = 1'b1;
`else
   localparam bit AutoRepeat = 1'b0;
`endif

   logic        clk_scan = 1'b0;
   logic        rst;
   logic        btn_up, btn_down, btn_step;
   logic [15:0] freq;
   logic [1:0]  step_sel;
   logic        freq_changed;

   int checks = 0;
   int errors = 0;
   int modelFreq;
   int modelSel;
   int inlinePulses;

   freq_setter #(
      .DEBOUNCE_MS(Deb), .REPEAT_DELAY_MS(RepeatDelay), .REPEAT_RATE_MS(RepeatRate),
      .FREQ_RESET(FreqReset), .FREQ_MAX(FreqMax)
   ) dut (
      .clk_scan(clk_scan), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .btn_step(btn_step), .freq(freq), .step_sel(step_sel), .freq_changed(freq_changed)
   );

   always #5 clk_scan = ~clk_scan;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_scan);
      #1;
   endtask

   // Step cycle relative to raw press start: first step after sync+debounce+edge,
   // then repeats at +delay, +delay+rate ... while the debounced level is still high.
   function automatic bit isStepCycle(input int i, input int hold);
      if (i == Latency) return 1'b1;
      if (!AutoRepeat) return 1'b0;
      if (i < Latency + RepeatDelay) return 1'b0;
      if (i > hold + 2 + Deb) return 1'b0;
      return ((i - Latency - RepeatDelay) % RepeatRate) == 0;
   endfunction

   function automatic bit modelApply(input bit up);
      int old;
      int step;
      old  = modelFreq;
      step = 1;
      for (int k = 0; k < modelSel; k++) step = step * 10;
      if (up) modelFreq = (modelFreq + step > FreqMax) ? FreqMax : modelFreq + step;
      else    modelFreq = (modelFreq < step) ? 0 : modelFreq - step;
      return modelFreq != old;
   endfunction

   task automatic driveRaw(input int kind, input logic v);
      case (kind)
         0:       btn_up = v;
         1:       btn_down = v;
         2:       btn_step = v;
         default: begin btn_up = v; btn_down = v; end
      endcase
   endtask

   task automatic doReset();
      rst = 1'b1;
      btn_up = 1'b0; btn_down = 1'b0; btn_step = 1'b0;
      repeat (2) tick();
      checkOutput("reset_freq", 32'(freq), 32'(FreqReset));
      checkOutput("reset_sel", 32'(step_sel), 32'(0));
      checkOutput("reset_pulse", 32'(freq_changed), 32'(0));
      rst = 1'b0;
      modelFreq = FreqReset;
      modelSel  = 0;
      tick();
   endtask

   // kind: 0 up, 1 down, 2 step, 3 up+down together
   task automatic applyStimulus(input int kind, input int hold, input int glitches);
      int pulses;
      int expPulses;
      int hi;
      int lo;
      bit changed;
      pulses = 0;
      expPulses = 0;
      for (int g = 0; g < glitches; g++) begin
         hi = $urandom_range(1, 5);
         lo = $urandom_range(2, 6);
         driveRaw(kind, 1'b1);
         repeat (hi) begin tick(); if (freq_changed === 1'b1) pulses++; end
         driveRaw(kind, 1'b0);
         repeat (lo) begin tick(); if (freq_changed === 1'b1) pulses++; end
      end
      if (glitches > 0) begin
         checkOutput("glitch_freq", 32'(freq), 32'(modelFreq));
         checkOutput("glitch_pulses", 32'(pulses), 32'(0));
      end
      pulses = 0;
      driveRaw(kind, 1'b1);
      for (int i = 1; i <= hold + Deb + 10; i++) begin
         tick();
         if (freq_changed === 1'b1) pulses++;
         if (i == Latency - 1) checkOutput("latency_early", 32'(freq), 32'(modelFreq));
         if (kind < 2 && isStepCycle(i, hold)) begin
            changed = modelApply(kind == 0);
            if (changed) expPulses++;
            checkOutput("step_freq", 32'(freq), 32'(modelFreq));
            checkOutput("step_pulse", 32'(freq_changed), 32'(changed));
         end
         if (kind == 2 && i == Latency) begin
            modelSel = (modelSel + 1) % 4;
            checkOutput("step_sel", 32'(step_sel), 32'(modelSel));
         end
         if (i == hold) driveRaw(kind, 1'b0);
      end
      checkOutput("press_pulses", 32'(pulses), 32'(expPulses));
      checkOutput("press_freq", 32'(freq), 32'(modelFreq));
      checkOutput("press_sel", 32'(step_sel), 32'(modelSel));
   endtask

   task automatic stepTo(input int sel);
      while (modelSel != sel) applyStimulus(2, 30, 0);
   endtask

   initial begin
      doReset();

      // Glitch bursts then a clean hold: a single step at the latency edge.
      applyStimulus(0, 30, 3);
      checkOutput("first_press", 32'(freq), 32'(1001));

      // Long hold: repeats only in the auto-repeat build.
      doReset();
      applyStimulus(0, 1000, 0);
      checkOutput("repeat_total", 32'(freq), AutoRepeat ? 32'(1006) : 32'(1001));

      // Saturation at FREQ_MAX.
      doReset();
      stepTo(3);
      repeat (8) applyStimulus(0, 30, 0);
      stepTo(2);
      repeat (5) applyStimulus(0, 30, 0);
      checkOutput("setup_9500", 32'(freq), 32'(9500));
      stepTo(3);
      applyStimulus(0, 30, 0);
      checkOutput("sat_top", 32'(freq), 32'(9999));
      applyStimulus(0, 30, 0);

      // Saturation at zero.
      doReset();
      stepTo(2);
      repeat (9) applyStimulus(1, 30, 0);
      stepTo(1);
      repeat (5) applyStimulus(1, 30, 0);
      stepTo(2);
      checkOutput("setup_50", 32'(freq), 32'(50));
      applyStimulus(1, 30, 0);
      checkOutput("sat_bottom", 32'(freq), 32'(0));
      repeat (2) applyStimulus(1, 30, 0);

      // Both buttons together: no step.
      doReset();
      applyStimulus(3, 40, 0);

      // Down pressed during an up hold: lockout until both released.
      inlinePulses = 0;
      btn_up = 1'b1;
      for (int i = 1; i <= 760; i++) begin
         tick();
         if (freq_changed === 1'b1) inlinePulses++;
         if (i == Latency) void'(modelApply(1'b1));
         if (i == 100) btn_down = 1'b1;
         if (i == 200) btn_down = 1'b0;
         if (i == 700) btn_up = 1'b0;
      end
      checkOutput("lockout_pulses", 32'(inlinePulses), 32'(1));
      checkOutput("lockout_freq", 32'(freq), 32'(modelFreq));

      // Fourth step press wraps 3 -> 0.
      stepTo(3);
      applyStimulus(2, 30, 0);
      checkOutput("sel_wrap", 32'(step_sel), 32'(0));

      // Asynchronous reset mid-hold, then the held button re-arms as a new press.
      doReset();
      btn_up = 1'b1;
      for (int i = 1; i <= 650; i++) begin
         tick();
         if (isStepCycle(i, 100000)) begin
            void'(modelApply(1'b1));
            checkOutput("pre_reset_freq", 32'(freq), 32'(modelFreq));
         end
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_freq", 32'(freq), 32'(FreqReset));
      checkOutput("async_rst_sel", 32'(step_sel), 32'(0));
      checkOutput("async_rst_pulse", 32'(freq_changed), 32'(0));
      modelFreq = FreqReset;
      modelSel  = 0;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= Latency; i++) begin
         tick();
         if (i == Latency - 1) checkOutput("rearm_early", 32'(freq), 32'(modelFreq));
      end
      void'(modelApply(1'b1));
      checkOutput("rearm_freq", 32'(freq), 32'(modelFreq));
      checkOutput("rearm_pulse", 32'(freq_changed), 32'(1));
      btn_up = 1'b0;
      repeat (40) tick();

      // Random presses against the model.
      for (int n = 0; n < 12; n++) begin
         applyStimulus($urandom_range(0, 2), $urandom_range(30, 120), $urandom_range(0, 2));
      end
      applyStimulus($urandom_range(0, 1), $urandom_range(600, 900), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_setter.md
FREQ_SETTER -- requirements
Module: freq_setter

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_MS, default 20, meaning consecutive stable clk_scan cycles required before a button level is accepted.
- REQ-002 The block SHALL have parameter REPEAT_DELAY_MS, default 500, meaning hold time before auto-repeat starts.
- REQ-003 The block SHALL have parameter REPEAT_RATE_MS, default 100, meaning the auto-repeat step period.
- REQ-004 The block SHALL have parameter FREQ_RESET, default 1000, meaning freq value after reset.
- REQ-005 The block SHALL have parameter FREQ_MAX, default 9999, meaning the upper saturation limit (FREQ_MIN fixed at 0).
- REQ-006 The block SHALL have port clk_scan, input, 1 bit: 1 kHz clock; all logic is on its rising edge.
- REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-008 The block SHALL have ports btn_up, btn_down and btn_step, input, 1 bit each: raw, asynchronous, active-high push buttons.
- REQ-009 The block SHALL have port freq, output, 16 bits: the frequency setpoint in Hz, which feeds the display driver and the generator.
- REQ-010 The block SHALL have port step_sel, output, 2 bits: current step size, where 0=1, 1=10, 2=100, 3=1000.
- REQ-011 The block SHALL have port freq_changed, output, 1 bit: a one-cycle pulse on every cycle in which freq changes value.

Function
- REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer; a debounced level changes only after DEBOUNCE_MS consecutive cycles with the synchronized level differing from it.
- REQ-013 A debounced rising edge of btn_step SHALL advance step_sel by 1, wrapping 3->0; btn_step has no auto-repeat.
- REQ-014 Per-direction control SHALL be an FSM with states IDLE, HOLD_WAIT, REPEAT.
- REQ-015 IDLE->HOLD_WAIT on a debounced up/down rising edge: apply one step and load the hold counter.
- REQ-016 HOLD_WAIT->REPEAT when the button has been held REPEAT_DELAY_MS cycles: apply one step.
- REQ-017 In REPEAT, SHALL apply one step every REPEAT_RATE_MS cycles.
- REQ-018 From any state, the FSM SHALL go to IDLE on debounced release, with no step on release.
- REQ-019 Step application: up: freq <= min(freq+step, FREQ_MAX); down: freq <= (freq<step) ? 0 : freq-step; arithmetic SHALL be at least 17 bits wide before saturation.
- REQ-020 When both debounced up and down are high, no step SHALL be applied, the FSM SHALL return to IDLE, and it SHALL re-arm only after both are released.
- REQ-021 freq_changed SHALL assert only if the saturated result differs from the old freq; pressing up at FREQ_MAX gives no pulse.
- REQ-022 A step_sel change during a HOLD_WAIT/REPEAT SHALL take effect at the next applied step.
- REQ-023 Latency: with raw btn_up held from cycle 0, freq SHALL update at the clk_scan edge 2+DEBOUNCE_MS+1 cycles later, with freq_changed high in that same cycle.

Reset
- REQ-024 On rst high, asynchronously: freq=FREQ_RESET, step_sel=0, freq_changed=0, FSM=IDLE, all counters and synchronizer/debounce flops=0.
- REQ-025 A button held through reset release SHALL be treated as a new press once debounced.

Configuration
- REQ-026 With FREQ_SETTER_AUTOREPEAT_EN defined, HOLD_WAIT and REPEAT SHALL operate as above; undefined, the FSM SHALL stay in HOLD_WAIT until release (exactly one step per press) and no repeat counter SHALL be built.

Structure
- REQ-027 Package freq_setter_pkg SHALL hold the FSM state encoding, the step lookup (1/10/100/1000) and the default timing constants.
- REQ-028 Sub-module btn_debounce (synchronizer plus debounce counter, parameter DEBOUNCE_MS) SHALL be instantiated three times.

Verification
- REQ-029 Reset -> freq=1000, step_sel=0, freq_changed=0.
- REQ-030 Raw btn_up with 5-cycle glitch bursts then held 30 cycles (DEBOUNCE_MS=20) -> no change during glitches; exactly one step, freq=1001 at cycle 23 of the hold.
- REQ-031 step_sel=3, freq=9500, up press -> freq=9999 with pulse; second press -> freq stays 9999, no pulse.
- REQ-032 step_sel=2, freq=50, down press -> freq=0; further down presses -> freq stays 0, no pulse.
- REQ-033 AUTOREPEAT_EN, step_sel=0, up held 1000 cycles -> 1 step at press, then steps at +500, +600 ... ; freq=1000+1+5=1006 at release (timing relative to debounced edge).
- REQ-034 up and down both held, and a 4th btn_step press -> freq unchanged, step_sel wraps 3->0; rst asserted mid-REPEAT -> immediate reset values.
